ahb_arbiter: RTL and testbench
==============================

# ahb_arbiter

Round-robin AHB bus arbiter that shares one AHB-Lite slave segment between up to NUM_MASTERS `ahb_master` instances. It samples each master's bus request and lock, tracks burst progress on the shared bus, and hands the bus over only at legal AHB boundaries. It drives the per-master `o_hgrant` vector and the `o_hmaster` select used by the address/data muxes in front of `ahb_slave_sim` or real slaves.

## Interface
Parameters:
- NUM_MASTERS, 4, number of requesters (2..8)
- DEFAULT_MASTER, 0, master granted when nobody requests
- MAX_BEATS, 16, beat limit for undefined-length INCR bursts (used only with AHB_ARB_BEAT_LIMIT_EN)

Ports:
- i_hclk  in  1  bus clock; all state on rising edge
- i_hreset  in  1  asynchronous, active-high reset
- i_hbusreq  in  NUM_MASTERS  per-master bus request
- i_hlock  in  NUM_MASTERS  per-master locked-transfer request
- i_htrans  in  2  HTRANS of the shared (muxed) address bus
- i_hburst  in  3  HBURST of the shared address bus
- i_hready  in  1  shared HREADY
- o_hgrant  out  NUM_MASTERS  one-hot grant
- o_hmaster  out  $clog2(NUM_MASTERS)  index of the master owning the address phase
- o_hmastlock  out  1  current address phase is locked

## Operation
- Reset: o_hgrant = one-hot(DEFAULT_MASTER), o_hmaster = DEFAULT_MASTER, o_hmastlock = 0, FSM = ARB_IDLE, priority pointer = DEFAULT_MASTER+1, beat counter = 0.
- Address beat accepted = i_htrans[1] & i_hready (NONSEQ or SEQ).
- Beat counter: loaded on an accepted NONSEQ with length from i_hburst (SINGLE 1, INCR4/WRAP4 4, INCR8/WRAP8 8, INCR16/WRAP16 16, INCR 0 = undefined). Decremented on each accepted SEQ. It is a 5-bit counter, and it saturates at 0.
- Arbitration point (AP): i_hready high and any of the following holds: FSM in ARB_IDLE; i_htrans IDLE; a fixed burst has its last beat accepted this cycle; an INCR burst owner has i_hbusreq low.
- At AP, the arbiter picks the first requester at or after the priority pointer, wrapping modulo NUM_MASTERS. If none, it picks DEFAULT_MASTER. The pointer then moves to winner+1, wrapping.
- FSM states and transitions:
  - ARB_IDLE: no owner request. Go to ARB_BUSY when an accepted NONSEQ has hbusreq set.
  - ARB_BUSY: burst in progress. At AP, re-arbitrate and go to ARB_IDLE if there is no request. Go to ARB_LOCKED if the owner has i_hlock set at NONSEQ.
  - ARB_LOCKED: no AP is honoured while owner i_hlock stays high. After i_hlock drops, the first AP re-arbitrates and returns to ARB_BUSY or ARB_IDLE.
- BUSY transfers (i_htrans = 2'b01) neither count beats nor create an AP.
- Simultaneous requests are resolved by the pointer only; there is no fixed priority.
- A request that arrives on the same cycle as an AP is eligible.

## Timing
- o_hgrant is registered and changes on the clock edge after an AP, and only when i_hready is high.
- o_hmaster is registered and follows o_hgrant on the next i_hready-high edge. This keeps it aligned with the address phase that the new master drives.
- o_hmastlock is registered with o_hmaster. It equals the i_hlock of the granted master.
- With i_hready low, all outputs and state hold.
- Reset asserted mid-burst: all outputs return to reset values asynchronously. There is no attempt to complete the burst.
- Handover latency: a requester on an idle bus sees o_hgrant 1 cycle after asserting i_hbusreq, and o_hmaster 2 cycles after.

## Configuration
- AHB_ARB_BEAT_LIMIT_EN defined:
  - An undefined-length INCR burst also creates an AP once MAX_BEATS beats have been accepted and another master is requesting.
  - The owner loses its grant and must restart with NONSEQ.
  - Locked bursts are exempt.
- AHB_ARB_BEAT_LIMIT_EN not defined: INCR bursts hold the bus until the owner drops i_hbusreq or issues IDLE, and MAX_BEATS is ignored.

## Structure
- Shared package `ahb_pkg`:
  - htrans/hburst encodings (IDLE, BUSY, NONSEQ, SEQ; SINGLE…WRAP16)
  - arbiter state enum
  - burst-length decode function
- One sub-module, `ahb_rr_pick`: combinational round-robin picker taking request vector and pointer, returning one-hot winner, index and a valid flag.

## Test plan
- Reset with all i_hbusreq = 0 -> o_hgrant = 4'b0001, o_hmaster = 0, o_hmastlock = 0, and they hold for 10 cycles.
- Masters 1 and 2 request together, each issuing INCR4 -> master 1 is granted first. Grant moves to 2 only after its 4th beat is accepted, and o_hmaster changes exactly one hready edge later.
- Master 3 issues INCR8 while i_hready is low for 3 cycles mid-burst -> beat count stays 8, and the grant is held until the 8th accepted beat.
- Master 0 holds i_hlock with 3 SINGLE transfers while master 2 requests -> no handover until i_hlock drops, and o_hmastlock = 1 throughout.
- Masters 0..3 request continuously with SINGLE transfers -> grants cycle 0,1,2,3,0 with no starvation.
- With AHB_ARB_BEAT_LIMIT_EN, MAX_BEATS = 16: master 1 runs INCR for 40 beats while master 2 requests -> the grant moves to 2 after beat 16. Without the macro, master 1 keeps the bus for all 40 beats.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg
//   Shared AHB definitions for the bus arbiter:
//     htrans_e     - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ)
//     hburst_e     - HBURST encodings (SINGLE .. INCR16)
//     arb_state_e  - arbiter FSM states
//     burst_len()  - beat count of a burst type, 0 for undefined-length INCR
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'b000,
      HBURST_INCR   = 3'b001,
      HBURST_WRAP4  = 3'b010,
      HBURST_INCR4  = 3'b011,
      HBURST_WRAP8  = 3'b100,
      HBURST_INCR8  = 3'b101,
      HBURST_WRAP16 = 3'b110,
      HBURST_INCR16 = 3'b111
   } hburst_e;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'b00,
      ARB_BUSY   = 2'b01,
      ARB_LOCKED = 2'b10
   } arb_state_e;

   function automatic logic [4:0] burst_len(input logic [2:0] hburst);
      logic [4:0] len;
      case (hburst)
         HBURST_SINGLE:                len = 5'd1;
         HBURST_WRAP4,  HBURST_INCR4:  len = 5'd4;
         HBURST_WRAP8,  HBURST_INCR8:  len = 5'd8;
         HBURST_WRAP16, HBURST_INCR16: len = 5'd16;
         default:                      len = 5'd0;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// ahb_rr_pick
//   Combinational round-robin picker. Returns the first set bit of req at or
//   after ptr, wrapping modulo N.
//   Ports:
//     req     in  N   request vector
//     ptr     in  IW  starting index for the search
//     onehot  out N   one-hot winner (all zero when nothing requests)
//     idx     out IW  winner index (0 when nothing requests)
//     valid   out 1   at least one request was found
module ahb_rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          valid
);

   logic [IW-1:0] cand;

   always_comb begin
      cand  = '0;
      idx   = '0;
      valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         cand = IW'((int'(ptr) + i) % N);
         if (!valid && req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
      onehot = valid ? (N'(1) << idx) : '0;
   end

endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter
//   Round-robin arbiter sharing one AHB-Lite slave segment between up to
//   NUM_MASTERS masters. Hands the bus over only at burst boundaries, idle
//   cycles, INCR release, or after lock is dropped.
//   Optional feature macro: AHB_ARB_BEAT_LIMIT_EN - undefined-length INCR
//   bursts are cut after MAX_BEATS beats when another master is requesting.
//   Ports:
//     i_hclk       in   1            bus clock, rising edge
//     i_hreset     in   1            asynchronous active-high reset
//     i_hbusreq    in   NUM_MASTERS  per-master bus request
//     i_hlock      in   NUM_MASTERS  per-master locked-transfer request
//     i_htrans     in   2            HTRANS of the shared address bus
//     i_hburst     in   3            HBURST of the shared address bus
//     i_hready     in   1            shared HREADY
//     o_hgrant     out  NUM_MASTERS  one-hot grant
//     o_hmaster    out  clog2(N)     owner of the current address phase
//     o_hmastlock  out  1            current address phase is locked
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ARB_IDLE   | no burst owner; every ready non-BUSY cycle arbitrates
//   ARB_BUSY   | burst in progress; arbitrate only at burst boundaries
//   ARB_LOCKED | locked sequence; no handover while owner holds i_hlock
module ahb_arbiter
   import ahb_pkg::*;
#(
   parameter int NUM_MASTERS    = 4,
   parameter int DEFAULT_MASTER = 0,
   parameter int MAX_BEATS      = 16
) (
   input  logic                           i_hclk,
   input  logic                           i_hreset,
   input  logic [NUM_MASTERS-1:0]         i_hbusreq,
   input  logic [NUM_MASTERS-1:0]         i_hlock,
   input  logic [1:0]                     i_htrans,
   input  logic [2:0]                     i_hburst,
   input  logic                           i_hready,
   output logic [NUM_MASTERS-1:0]         o_hgrant,
   output logic [$clog2(NUM_MASTERS)-1:0] o_hmaster,
   output logic                           o_hmastlock
);

   localparam int IW     = $clog2(NUM_MASTERS);
   localparam int BEAT_W = $clog2(MAX_BEATS + 1);

   localparam logic [IW-1:0]          DEF_IDX = IW'(DEFAULT_MASTER);
   localparam logic [IW-1:0]          DEF_PTR = IW'((DEFAULT_MASTER + 1) % NUM_MASTERS);
   localparam logic [NUM_MASTERS-1:0] DEF_GNT = NUM_MASTERS'(1) << DEFAULT_MASTER;

`ifdef AHB_ARB_BEAT_LIMIT_EN
   localparam logic BEAT_LIMIT_EN = 1'b1;
`else
   localparam logic BEAT_LIMIT_EN = 1'b0;
`endif

   arb_state_e             state, state_nxt;
   logic [NUM_MASTERS-1:0] grant;
   logic [IW-1:0]          gnt_idx;
   logic [IW-1:0]          hmaster;
   logic                   hmastlock;
   logic [IW-1:0]          ptr;
   logic [4:0]             beat_cnt;
   logic                   incr_q;
   logic [BEAT_W-1:0]      incr_beats;

   logic                   acc, nonseq_acc, seq_acc;
   logic [4:0]             len_in;
   logic                   incr_now;
   logic                   owner_req, owner_lock;
   logic [NUM_MASTERS-1:0] owner_onehot;
   logic                   others_req;
   logic                   last_fixed, incr_release, beat_hit, limit;
   logic                   handover, start_burst, lock_start, lock_hold;
   logic                   ap_cond, ap;

   logic [NUM_MASTERS-1:0] pick_onehot;
   logic [IW-1:0]          pick_idx;
   logic                   pick_valid;
   logic [NUM_MASTERS-1:0] win_onehot;
   logic [IW-1:0]          win_idx;

   ahb_rr_pick #(
      .N  (NUM_MASTERS),
      .IW (IW)
   ) u_pick (
      .req    (i_hbusreq),
      .ptr    (ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .valid  (pick_valid)
   );

   assign win_onehot = pick_valid ? pick_onehot : DEF_GNT;
   assign win_idx    = pick_valid ? pick_idx    : DEF_IDX;

   assign acc        = i_hready & i_htrans[1];
   assign nonseq_acc = acc & (i_htrans == HTRANS_NONSEQ);
   assign seq_acc    = acc & (i_htrans == HTRANS_SEQ);
   assign len_in     = burst_len(i_hburst);

   // On the NONSEQ beat the burst type comes straight from the bus; later
   // beats use the type captured at NONSEQ.
   assign incr_now = (i_htrans == HTRANS_NONSEQ) ? (i_hburst == HBURST_INCR) : incr_q;

   // The address-phase owner is the master that drives the burst.
   assign owner_req    = i_hbusreq[hmaster];
   assign owner_lock   = i_hlock[hmaster];
   assign owner_onehot = NUM_MASTERS'(1) << hmaster;
   assign others_req   = |(i_hbusreq & ~owner_onehot);

   // beat_cnt is loaded with the burst length on NONSEQ and drops once per
   // SEQ, so the final SEQ of a fixed burst arrives with beat_cnt == 2.
   assign last_fixed = (nonseq_acc & (len_in == 5'd1)) |
                       (seq_acc & ~incr_q & (beat_cnt == 5'd2));

   assign incr_release = incr_now & i_htrans[1] & ~owner_req;

   // incr_beats saturates at MAX_BEATS, so the limit fires on one beat only.
   assign beat_hit = (i_htrans == HTRANS_NONSEQ) ? (MAX_BEATS == 1)
                                                 : (incr_beats == BEAT_W'(MAX_BEATS - 1));
   assign limit    = BEAT_LIMIT_EN & acc & incr_now & beat_hit & others_req &
                     (state != ARB_LOCKED);

   // While a new grant has not yet reached o_hmaster, the bus still carries
   // the old owner's cycles; re-arbitrating then would steal the fresh grant.
   assign handover    = (gnt_idx != hmaster);
   assign start_burst = nonseq_acc & owner_req;
   assign lock_start  = nonseq_acc & owner_lock;
   assign lock_hold   = owner_lock & ((state == ARB_LOCKED) | lock_start);

   assign ap_cond = ((state == ARB_IDLE) & ~start_burst) |
                    (i_htrans == HTRANS_IDLE) |
                    last_fixed | incr_release | limit;

   assign ap = i_hready & ~handover & (i_htrans != HTRANS_BUSY) & ap_cond & ~lock_hold;

   always_comb begin
      state_nxt = state;
      unique case (state)
         ARB_IDLE: begin
            if (start_burst) state_nxt = lock_start ? ARB_LOCKED : ARB_BUSY;
         end
         ARB_BUSY: begin
            if (lock_start)             state_nxt = ARB_LOCKED;
            else if (ap && !pick_valid) state_nxt = ARB_IDLE;
         end
         ARB_LOCKED: begin
            if (lock_start)             state_nxt = ARB_LOCKED;
            else if (ap)                state_nxt = pick_valid ? ARB_BUSY : ARB_IDLE;
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge i_hclk or posedge i_hreset) begin
      if (i_hreset) begin
         state      <= ARB_IDLE;
         grant      <= DEF_GNT;
         gnt_idx    <= DEF_IDX;
         hmaster    <= DEF_IDX;
         hmastlock  <= 1'b0;
         ptr        <= DEF_PTR;
         beat_cnt   <= '0;
         incr_q     <= 1'b0;
         incr_beats <= '0;
      end else begin
         state <= state_nxt;
         if (ap) begin
            grant   <= win_onehot;
            gnt_idx <= win_idx;
            ptr     <= (int'(win_idx) == NUM_MASTERS - 1) ? '0 : win_idx + 1'b1;
         end
         if (i_hready) begin
            hmaster   <= gnt_idx;
            hmastlock <= i_hlock[gnt_idx];
         end
         if (nonseq_acc) begin
            beat_cnt   <= len_in;
            incr_q     <= (i_hburst == HBURST_INCR);
            incr_beats <= BEAT_W'(1);
         end else if (seq_acc) begin
            if (beat_cnt != 5'd0)
               beat_cnt <= beat_cnt - 5'd1;
            if (incr_beats != BEAT_W'(MAX_BEATS))
               incr_beats <= incr_beats + BEAT_W'(1);
         end
      end
   end

   assign o_hgrant    = grant;
   assign o_hmaster   = hmaster;
   assign o_hmastlock = hmastlock;

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter
//   Directed bench for ahb_arbiter (4 masters, default master 0, MAX_BEATS 16).
//   Each step drives the shared bus, advances one clock, and checks outputs
//   1 time unit after the rising edge against hand-computed values.
module tb_ahb_arbiter;

   localparam logic [1:0] T_IDLE = 2'b00;
   localparam logic [1:0] T_NSEQ = 2'b10;
   localparam logic [1:0] T_SEQ  = 2'b11;
   localparam logic [2:0] B_SINGLE = 3'b000;
   localparam logic [2:0] B_INCR   = 3'b001;
   localparam logic [2:0] B_INCR4  = 3'b011;
   localparam logic [2:0] B_INCR8  = 3'b101;

`ifdef AHB_ARB_BEAT_LIMIT_EN
   localparam logic [3:0] GNT_AFTER_LIMIT = 4'b0100;
`else
   localparam logic [3:0] GNT_AFTER_LIMIT = 4'b0010;
`endif

   logic       i_hclk;
   logic       i_hreset;
   logic [3:0] i_hbusreq;
   logic [3:0] i_hlock;
   logic [1:0] i_htrans;
   logic [2:0] i_hburst;
   logic       i_hready;
   logic [3:0] o_hgrant;
   logic [1:0] o_hmaster;
   logic       o_hmastlock;

   int n_assert = 0;
   int n_fail   = 0;

   ahb_arbiter #(
      .NUM_MASTERS    (4),
      .DEFAULT_MASTER (0),
      .MAX_BEATS      (16)
   ) dut (
      .i_hclk      (i_hclk),
      .i_hreset    (i_hreset),
      .i_hbusreq   (i_hbusreq),
      .i_hlock     (i_hlock),
      .i_htrans    (i_htrans),
      .i_hburst    (i_hburst),
      .i_hready    (i_hready),
      .o_hgrant    (o_hgrant),
      .o_hmaster   (o_hmaster),
      .o_hmastlock (o_hmastlock)
   );

   initial i_hclk = 1'b0;
   always #5 i_hclk = ~i_hclk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] m,
                            input logic l);
      check({tag, ".hgrant"},    8'(o_hgrant),    8'(g));
      check({tag, ".hmaster"},   8'(o_hmaster),   8'(m));
      check({tag, ".hmastlock"}, 8'(o_hmastlock), 8'(l));
   endtask

   task automatic bus(input logic [1:0] t, input logic [2:0] b, input logic rdy,
                      input logic [3:0] req, input logic [3:0] lck);
      i_htrans  = t;
      i_hburst  = b;
      i_hready  = rdy;
      i_hbusreq = req;
      i_hlock   = lck;
   endtask

   task automatic tick();
      @(posedge i_hclk);
      #1;
   endtask

   initial begin
      i_hreset = 1'b1;
      bus(T_IDLE, B_SINGLE, 1'b1, 4'b0000, 4'b0000);
      #12;
      check_all("reset", 4'b0001, 2'd0, 1'b0);
      i_hreset = 1'b0;

      // Idle bus holds the default master.
      for (int i = 0; i < 10; i++) begin
         tick();
         check_all("idle_hold", 4'b0001, 2'd0, 1'b0);
      end

      // Masters 1 and 2 request together, INCR4 each.
      bus(T_IDLE, B_SINGLE, 1'b1, 4'b0110, 4'b0000);
      tick(); check_all("m12_grant1", 4'b0010, 2'd0, 1'b0);
      tick(); check_all("m12_hmaster1", 4'b0010, 2'd1, 1'b0);
      bus(T_NSEQ, B_INCR4, 1'b1, 4'b0110, 4'b0000);
      tick(); check("m1_beat1", 8'(o_hgrant), 8'b0010);
      bus(T_SEQ, B_INCR4, 1'b1, 4'b0110, 4'b0000);
      tick(); check("m1_beat2", 8'(o_hgrant), 8'b0010);
      tick(); check("m1_beat3", 8'(o_hgrant), 8'b0010);
      tick(); check_all("m1_beat4", 4'b0100, 2'd1, 1'b0);
      bus(T_IDLE, B_SINGLE, 1'b0, 4'b0100, 4'b0000);
      tick(); check_all("m2_wait_nready", 4'b0100, 2'd1, 1'b0);
      i_hready = 1'b1;
      tick(); check_all("m2_hmaster", 4'b0100, 2'd2, 1'b0);
      bus(T_NSEQ, B_INCR4, 1'b1, 4'b0100, 4'b0000);
      tick(); check("m2_beat1", 8'(o_hgrant), 8'b0100);
      bus(T_SEQ, B_INCR4, 1'b1, 4'b0100, 4'b0000);
      tick(); check("m2_beat2", 8'(o_hgrant), 8'b0100);
      tick(); check("m2_beat3", 8'(o_hgrant), 8'b0100);
      i_hbusreq = 4'b0000;
      tick(); check_all("m2_beat4_default", 4'b0001, 2'd2, 1'b0);
      bus(T_IDLE, B_SINGLE, 1'b1, 4'b0000, 4'b0000);
      tick(); check_all("back_to_m0", 4'b0001, 2'd0, 1'b0);

      // Master 3 INCR8 with three wait states mid-burst; master 0 waiting.
      bus(T_IDLE, B_SINGLE, 1'b1, 4'b1000, 4'b0000);
      tick(); check("m3_grant", 8'(o_hgrant), 8'b1000);
      tick(); check("m3_hmaster", 8'(o_hmaster), 8'd3);
      bus(T_NSEQ, B_INCR8, 1'b1, 4'b1000, 4'b0000);
      tick(); check("m3_beat1", 8'(o_hgrant), 8'b1000);
      bus(T_SEQ, B_INCR8, 1'b1, 4'b1001, 4'b0000);
      for (int b = 2; b <= 4; b++) begin
         tick(); check("m3_beat2_4", 8'(o_hgrant), 8'b1000);
      end
      i_hready = 1'b0;
      for (int w = 0; w < 3; w++) begin
         tick(); check("m3_wait", 8'(o_hgrant), 8'b1000);
      end
      i_hready = 1'b1;
      for (int b = 5; b <= 7; b++) begin
         tick(); check("m3_beat5_7", 8'(o_hgrant), 8'b1000);
      end
      tick(); check_all("m3_beat8", 4'b0001, 2'd3, 1'b0);

      // Master 0 locked SINGLEs while master 2 requests.
      bus(T_IDLE, B_SINGLE, 1'b1, 4'b0001, 4'b0001);
      tick(); check_all("lock_own", 4'b0001, 2'd0, 1'b1);
      bus(T_NSEQ, B_SINGLE, 1'b1, 4'b0101, 4'b0001);
      for (int s = 0; s < 3; s++) begin
         tick(); check_all("lock_single", 4'b0001, 2'd0, 1'b1);
      end
      i_htrans = T_IDLE;
      tick(); check_all("lock_idle_held", 4'b0001, 2'd0, 1'b1);
      bus(T_IDLE, B_SINGLE, 1'b1, 4'b0100, 4'b0000);
      tick(); check_all("unlock_grant2", 4'b0100, 2'd0, 1'b0);
      tick(); check_all("unlock_hmaster2", 4'b0100, 2'd2, 1'b0);

      // Reset asserted mid-burst between clock edges.
      bus(T_NSEQ, B_INCR4, 1'b1, 4'b0100, 4'b0000);
      tick();
      bus(T_SEQ, B_INCR4, 1'b1, 4'b0100, 4'b0000);
      tick(); check_all("pre_reset", 4'b0100, 2'd2, 1'b0);
      #3 i_hreset = 1'b1;
      #1 check_all("async_reset", 4'b0001, 2'd0, 1'b0);
      #1 i_hreset = 1'b0;

      // All four masters request, one SINGLE each when they own the bus.
      for (int k = 0; k < 5; k++) begin
         bus(T_NSEQ, B_SINGLE, 1'b1, 4'b1111, 4'b0000);
         tick(); check("rr_grant", 8'(o_hgrant), 8'(4'b0001 << ((k + 1) % 4)));
         i_htrans = T_IDLE;
         tick(); check("rr_hmaster", 8'(o_hmaster), 8'((k + 1) % 4));
      end

      // Master 1 undefined-length INCR for 40 beats while master 2 requests.
      bus(T_NSEQ, B_INCR, 1'b1, 4'b0110, 4'b0000);
      tick(); check("incr_beat1", 8'(o_hgrant), 8'b0010);
      i_htrans = T_SEQ;
      for (int n = 2; n <= 40; n++) begin
         tick();
         check("incr_beat", 8'(o_hgrant), 8'((n >= 16) ? GNT_AFTER_LIMIT : 4'b0010));
      end
      i_hbusreq = 4'b0100;
      tick(); check("incr_release", 8'(o_hgrant), 8'b0100);
      i_htrans = T_IDLE;
      tick(); check("incr_hmaster2", 8'(o_hmaster), 8'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
